dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the core load/store path, and port 1 is the external loader/debug path used to preload and inspect data memory.
- Arbitrates round-robin and supports locked bursts, capped at MAX_BURST beats.
- Drives the data memory's write enable, address and write-data inputs.
- Registers read data back to the owning requester and produces a stall for the core.
- Sits between the core datapath (ALU result / rs2 data) and data memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive beats one owner may take under lock (≥1).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req0_valid  input  1  core request
- req0_we  input  1  1=write, 0=read
- req0_addr  input  ADDR_W  core address
- req0_wdata  input  DATA_W  core write data
- req0_lock  input  1  hold ownership after this beat
- req0_ready  output  1  core beat accepted this cycle
- resp0_valid  output  1  response for a core beat accepted last cycle
- resp0_rdata  output  DATA_W  core read data
- req1_valid, req1_we, req1_addr, req1_wdata, req1_lock  inputs  as port 0  loader request
- req1_ready  output  1  loader beat accepted this cycle
- resp1_valid  output  1  response for a loader beat accepted last cycle
- resp1_rdata  output  DATA_W  loader read data
- core_stall  output  1  req0_valid && !req0_ready
- mem_we  output  1  data memory write enable
- mem_addr  output  ADDR_W  data memory address
- mem_wdata  output  DATA_W  data memory write data
- mem_rdata  input  DATA_W  data memory read data (combinational read)

Behaviour:
- States: IDLE, OWN0, OWN1.
- Registers: state, last_grant (1 bit), beat_cnt (ceil(log2(MAX_BURST+1)) bits), resp0/1_valid, resp0/1_rdata.
- Reset (rst=0, asynchronous): state=IDLE, last_grant=1 (so port 0 wins the first tie), beat_cnt=0, resp*_valid=0, resp*_rdata=0. mem_we=0 and both ready outputs are 0 while in reset.
- reqN_ready is 1 iff state==OWNN and reqN_valid==1.
- A beat is accepted in any cycle where reqN_valid && reqN_ready.
- Memory outputs are combinational:
  - In OWNN: mem_addr=reqN_addr, mem_wdata=reqN_wdata, mem_we=reqN_we && reqN_valid.
  - In IDLE: mem_we=0 and addr/wdata are 0.
- Response latency is 1 cycle. For a beat accepted in cycle t, respN_valid=1 at t+1 for exactly one cycle.
  - Read beat: respN_rdata = mem_rdata sampled at t.
  - Write beat: respN_rdata = 0 (response serves as the write acknowledge).
- A response pulses only for accepted beats. The other port's respM_valid stays 0.
- IDLE transitions:
  - No valid requests: stay in IDLE.
  - One valid request: go to that port's OWN state.
  - Both valid: go to OWN(~last_grant).
  - Arbitration costs one cycle; no beat is accepted in IDLE.
- Entering OWNN: last_grant←N, beat_cnt←0.
- In OWNN, on an accepted beat: beat_cnt increments. Ownership releases when reqN_lock==0 OR beat_cnt+1==MAX_BURST.
- In OWNN, reqN_valid==0 in a cycle: release immediately, with no beat.
- On release from OWNN, the next state is chosen in this order:
  - OWN(other) if the other port's valid is 1;
  - else OWNN re-entered (beat_cnt←0) if reqN_valid is 1 and the release was due to the MAX_BURST cap or lock dropping;
  - else IDLE.
- There is no switching latency: a directly granted other port can have a beat accepted in the very next cycle.
- Fairness: when both ports request continuously, neither waits more than MAX_BURST accepted beats plus 1 cycle.
- MAX_BURST=1: every beat releases ownership, so the ports strictly alternate under contention.
- Requests and lock are sampled only on accepted beats; lock on a non-accepted cycle is ignored.
- Reset mid-burst: immediate IDLE, the in-flight response is dropped (resp_valid=0), and no write is issued while rst=0.

Test Plan:
- Reset then single core read: req0_valid=1, we=0, addr=0x10, mem holds 0xDEADBEEF.
  - Cycle 1: IDLE→OWN0. Cycle 2: req0_ready=1. Cycle 3: resp0_valid=1, resp0_rdata=0xDEADBEEF.
  - core_stall=1 in cycle 1 only.
- Simultaneous requests from both ports, no lock, MAX_BURST=8, four beats each.
  - Grants alternate 0,1,0,1,…, starting with port 0.
  - Each port receives 4 resp_valid pulses; no IDLE cycles occur between grants.
- Locked loader burst: req1_lock=1 for 12 writes with addr 0x0..0x2C, core requesting throughout, MAX_BURST=8.
  - Exactly 8 loader beats are accepted, then OWN0 takes one core beat, then OWN1 resumes.
  - Memory contents are verified afterwards.
- Loader alone, locked, 10 beats: after beat 8, OWN1 is re-entered directly with beat_cnt=0, with no IDLE bubble.
- Reset mid-burst: rst=0 asserted asynchronously during OWN1 with write beat 3 pending.
  - mem_we drops to 0 immediately; resp1_valid=0; after release, state is IDLE and last_grant=1.
- Write ack plus read-back: core writes 0x12345678 to 0x40, then reads 0x40.
  - Write response has rdata=0; read response has rdata=0x12345678.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the core (port 0) and the loader (port 1):
// round-robin arbitration, locked bursts capped at MAX_BURST beats, one-cycle responses.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              core_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned     CntW    = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              resp0_valid_q, resp1_valid_q;
  logic [DATA_W-1:0] resp0_rdata_q, resp1_rdata_q;

  logic acc0, acc1;
  logic own_port, cur_valid, cur_lock, oth_valid;
  logic grant_en, grant_port, release_own, reenter;

  assign acc0 = (state_q == StOwn0) && req0_valid;
  assign acc1 = (state_q == StOwn1) && req1_valid;

  // Views of the current owner and the other port while in an OWN state.
  assign own_port  = (state_q == StOwn1);
  assign cur_valid = own_port ? req1_valid : req0_valid;
  assign cur_lock  = own_port ? req1_lock  : req0_lock;
  assign oth_valid = own_port ? req0_valid : req1_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    grant_en     = 1'b0;
    grant_port   = 1'b0;
    release_own  = 1'b0;
    reenter      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) begin
          grant_en   = 1'b1;
          grant_port = ~last_grant_q;
        end else if (req0_valid || req1_valid) begin
          grant_en   = 1'b1;
          grant_port = req1_valid;
        end
      end
      StOwn0, StOwn1: begin
        if (!cur_valid) begin
          release_own = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (!cur_lock || (beat_cnt_q == CntLast)) begin
            release_own = 1'b1;
            reenter     = 1'b1;
          end
        end
        if (release_own) begin
          if (oth_valid) begin
            grant_en   = 1'b1;
            grant_port = ~own_port;
          end else if (reenter) begin
            grant_en   = 1'b1;
            grant_port = own_port;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant_en) begin
      state_d      = grant_port ? StOwn1 : StOwn0;
      last_grant_d = grant_port;
      beat_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      beat_cnt_q    <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      resp0_valid_q <= acc0;
      resp1_valid_q <= acc1;
      // Write beats answer with zero data; the pulse itself is the acknowledge.
      if (acc0) resp0_rdata_q <= req0_we ? '0 : mem_rdata;
      if (acc1) resp1_rdata_q <= req1_we ? '0 : mem_rdata;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StOwn0: begin
        mem_we    = req0_we && req0_valid;
        mem_addr  = req0_addr;
        mem_wdata = req0_wdata;
      end
      StOwn1: begin
        mem_we    = req1_we && req1_valid;
        mem_addr  = req1_addr;
        mem_wdata = req1_wdata;
      end
      default: ;
    endcase
  end

  assign req0_ready  = acc0;
  assign req1_ready  = acc1;
  assign core_stall  = req0_valid && !acc0;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, directed corner sequences and a randomized
// run checked against a cycle-level ownership model with its own copy of memory.
module tb_dmem_port_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req0_lock, req0_ready, resp0_valid;
  logic [31:0] req0_addr, req0_wdata, resp0_rdata;
  logic        req1_valid, req1_we, req1_lock, req1_ready, resp1_valid;
  logic [31:0] req1_addr, req1_wdata, resp1_rdata;
  logic        core_stall, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .core_stall(core_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: word-addressed, combinational read, plus a bench preload path.
  logic [31:0] mem [256] = '{default: '0};
  logic        tb_wr = 1'b0;
  logic [7:0]  tb_idx = '0;
  logic [31:0] tb_dat = '0;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    else if (tb_wr) mem[tb_idx] <= tb_dat;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  // Vector table: both ports reading continuously, no lock.
  typedef struct {
    logic v0, v1;
    logic r0, r1, rv0, rv1, st;
  } vec_t;
  vec_t tbl[11];

  // Reference model: who owns the port, how many beats this tenure, who was granted last.
  int          m_owner, m_taken, m_last;
  logic        m_rv[2];
  logic [31:0] m_rd[2];
  logic [31:0] gold[256];

  task automatic model_reset();
    m_owner = -1; m_taken = 0; m_last = 1;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic model_step();
    logic v[2], w[2], l[2];
    logic [31:0] a[2], d[2];
    bit acc[2];
    bit rel, again;
    int p, o;
    v[0] = req0_valid; w[0] = req0_we; l[0] = req0_lock; a[0] = req0_addr; d[0] = req0_wdata;
    v[1] = req1_valid; w[1] = req1_we; l[1] = req1_lock; a[1] = req1_addr; d[1] = req1_wdata;
    for (int i = 0; i < 2; i++) begin
      acc[i] = (m_owner == i) && v[i];
      m_rv[i] = acc[i];
      if (acc[i]) m_rd[i] = w[i] ? 32'h0 : gold[a[i][9:2]];
    end
    for (int i = 0; i < 2; i++) if (acc[i] && w[i]) gold[a[i][9:2]] = d[i];
    if (m_owner < 0) begin
      if (v[0] && v[1]) m_owner = 1 - m_last;
      else if (v[0]) m_owner = 0;
      else if (v[1]) m_owner = 1;
      if (m_owner >= 0) begin m_last = m_owner; m_taken = 0; end
    end else begin
      p = m_owner; o = 1 - p; rel = 0; again = 0;
      if (!v[p]) rel = 1;
      else begin
        m_taken++;
        if (!l[p] || m_taken == MAXB) begin rel = 1; again = 1; end
      end
      if (rel) begin
        if (v[o]) begin m_owner = o; m_last = o; m_taken = 0; end
        else if (again) begin m_last = p; m_taken = 0; end
        else m_owner = -1;
      end
    end
  endtask

  int k, cyc;
  bit acc, started;
  int seq[$];
  logic e_we;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    // Requests during reset must be ignored.
    req0_valid = 1; req0_we = 1; req1_valid = 1; req1_we = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready0", req0_ready, 0);
    check("reset_ready1", req1_ready, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_resp0_valid", resp0_valid, 0);
    check("reset_resp1_valid", resp1_valid, 0);
    check("reset_resp0_rdata", resp0_rdata, 0);
    idle_inputs();
    tb_wr = 1; tb_idx = 8'd4; tb_dat = 32'hDEADBEEF;
    @(posedge clk); #1; tb_wr = 0;
    @(negedge clk); rst = 1'b1;
    next_cycle();

    // Single core read of 0x10.
    req0_valid = 1; req0_we = 0; req0_addr = 32'h10;
    @(negedge clk);
    check("rd_c1_stall", core_stall, 1);
    check("rd_c1_ready0", req0_ready, 0);
    next_cycle();
    @(negedge clk);
    check("rd_c2_ready0", req0_ready, 1);
    check("rd_c2_stall", core_stall, 0);
    check("rd_c2_mem_addr", mem_addr, 32'h10);
    check("rd_c2_mem_we", mem_we, 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd_c3_resp0_valid", resp0_valid, 1);
    check("rd_c3_resp0_rdata", resp0_rdata, 32'hDEADBEEF);
    check("rd_c3_resp1_valid", resp1_valid, 0);
    next_cycle();
    @(negedge clk);
    check("rd_c4_resp0_valid", resp0_valid, 0);

    // Contention table: strict alternation starting with port 0, no idle gaps.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 1, 0, 1};
    tbl[3]  = '{1, 1, 1, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 1, 1, 0, 1};
    tbl[5]  = '{1, 1, 1, 0, 0, 1, 0};
    tbl[6]  = '{1, 1, 0, 1, 1, 0, 1};
    tbl[7]  = '{1, 1, 1, 0, 0, 1, 0};
    tbl[8]  = '{1, 1, 0, 1, 1, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req0_valid = tbl[i].v0; req0_addr = 32'h20;
      req1_valid = tbl[i].v1; req1_addr = 32'h24;
      @(negedge clk);
      check($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
      check($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
      check($sformatf("tbl%0d_resp0_valid", i), resp0_valid, tbl[i].rv0);
      check($sformatf("tbl%0d_resp1_valid", i), resp1_valid, tbl[i].rv1);
      check($sformatf("tbl%0d_stall", i), core_stall, tbl[i].st);
      next_cycle();
    end
    idle_inputs();

    // Locked loader burst of 12 writes against a continuously requesting core.
    do_reset();
    k = 0; cyc = 0; started = 0; seq.delete();
    while (k < 12 && cyc < 60) begin
      req1_valid = 1; req1_we = 1; req1_lock = 1;
      req1_addr = k * 4; req1_wdata = 32'hA000_0000 + k;
      if (cyc >= 1) begin req0_valid = 1; req0_we = 0; req0_addr = 32'h200; end
      @(negedge clk);
      acc = req1_ready;
      if (req0_ready || req1_ready) started = 1;
      if (started) seq.push_back(req1_ready ? 1 : (req0_ready ? 0 : 2));
      next_cycle();
      if (acc) k++;
      cyc++;
    end
    idle_inputs();
    check("lock_seq_len", seq.size(), 13);
    for (int i = 0; i < 13 && i < seq.size(); i++)
      check($sformatf("lock_seq%0d", i), seq[i], (i == 8) ? 0 : 1);
    repeat (2) next_cycle();
    for (int i = 0; i < 12; i++)
      check($sformatf("lock_mem%0d", i), mem[i], 32'hA000_0000 + i);

    // Loader alone, locked, 10 beats: cap re-entry without a bubble.
    do_reset();
    k = 0; cyc = 0; started = 0; seq.delete();
    while (k < 10 && cyc < 40) begin
      req1_valid = 1; req1_we = 1; req1_lock = 1;
      req1_addr = 32'h80 + k * 4; req1_wdata = 32'hB000_0000 + k;
      @(negedge clk);
      acc = req1_ready;
      if (req1_ready) started = 1;
      if (started) seq.push_back(req1_ready ? 1 : 0);
      next_cycle();
      if (acc) k++;
      cyc++;
    end
    idle_inputs();
    check("solo_seq_len", seq.size(), 10);
    for (int i = 0; i < 10 && i < seq.size(); i++)
      check($sformatf("solo_seq%0d", i), seq[i], 1);

    // Core write ack followed by read-back.
    do_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h40; req0_wdata = 32'h12345678;
    @(negedge clk);
    check("wr_c1_ready0", req0_ready, 0);
    next_cycle();
    @(negedge clk);
    check("wr_c2_ready0", req0_ready, 1);
    check("wr_c2_mem_we", mem_we, 1);
    check("wr_c2_mem_wdata", mem_wdata, 32'h12345678);
    next_cycle();
    req0_we = 0;
    @(negedge clk);
    check("wr_c3_ready0", req0_ready, 1);
    check("wr_c3_resp0_valid", resp0_valid, 1);
    check("wr_c3_resp0_rdata", resp0_rdata, 32'h0);
    check("wr_c3_mem_we", mem_we, 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("wr_c4_resp0_valid", resp0_valid, 1);
    check("wr_c4_resp0_rdata", resp0_rdata, 32'h12345678);

    // Asynchronous reset with loader write beat 3 pending.
    do_reset();
    k = 0; cyc = 0;
    while (k < 2 && cyc < 20) begin
      req1_valid = 1; req1_we = 1; req1_lock = 1;
      req1_addr = 32'h300 + k * 4; req1_wdata = 32'h5500_0001 + k;
      @(negedge clk);
      acc = req1_ready;
      next_cycle();
      if (acc) k++;
      cyc++;
    end
    req1_addr = 32'h308; req1_wdata = 32'h5500_0003;
    @(negedge clk);
    check("rstmid_pending_ready1", req1_ready, 1);
    check("rstmid_pending_mem_we", mem_we, 1);
    #1 rst = 1'b0;
    #1;
    check("rstmid_mem_we", mem_we, 0);
    check("rstmid_ready1", req1_ready, 0);
    check("rstmid_resp1_valid", resp1_valid, 0);
    next_cycle();
    check("rstmid_mem_unwritten", mem[194], 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check("rstmid_idle_ready0", req0_ready, 0);
    check("rstmid_idle_ready1", req1_ready, 0);
    next_cycle();
    @(negedge clk);
    check("rstmid_tie_ready0", req0_ready, 1);
    check("rstmid_tie_ready1", req1_ready, 0);
    next_cycle();
    idle_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 256; i++) gold[i] = mem[i];
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      req0_valid = ($urandom_range(0, 99) < 70);
      req0_we    = $urandom_range(0, 1);
      req0_lock  = ($urandom_range(0, 99) < 60);
      req0_addr  = 32'h380 + ($urandom_range(0, 15) << 2);
      req0_wdata = $urandom;
      req1_valid = ($urandom_range(0, 99) < 70);
      req1_we    = $urandom_range(0, 1);
      req1_lock  = ($urandom_range(0, 99) < 60);
      req1_addr  = 32'h380 + ($urandom_range(0, 15) << 2);
      req1_wdata = $urandom;
      @(negedge clk);
      check("rnd_ready0", req0_ready, (m_owner == 0) && req0_valid);
      check("rnd_ready1", req1_ready, (m_owner == 1) && req1_valid);
      check("rnd_stall", core_stall, req0_valid && !(m_owner == 0));
      e_we = ((m_owner == 0) && req0_valid && req0_we) || ((m_owner == 1) && req1_valid && req1_we);
      check("rnd_mem_we", mem_we, e_we);
      if (e_we) check("rnd_mem_addr", mem_addr, (m_owner == 0) ? req0_addr : req1_addr);
      check("rnd_resp0_valid", resp0_valid, m_rv[0]);
      check("rnd_resp1_valid", resp1_valid, m_rv[1]);
      if (m_rv[0]) check("rnd_resp0_rdata", resp0_rdata, m_rd[0]);
      if (m_rv[1]) check("rnd_resp1_rdata", resp1_rdata, m_rd[1]);
      model_step();
      next_cycle();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
